// File: rtl/max_pool_seq.sv
// Sequential P x P max-pooling stage: captures an R x C map on start, scans one
// element per cycle, and publishes the pooled map atomically with a done pulse.
module max_pool_seq #(
    parameter int In_d_W = 18,
    parameter int R      = 4,
    parameter int C      = 4,
    parameter int P      = 2
) (
    input  logic                                clk,
    input  logic                                clr,
    input  logic                                start,
    input  logic [In_d_W*R*C-1:0]               X,
    output logic                                busy,
    output logic                                done,
    output logic [In_d_W*(R/P)*(C/P)-1:0]       Z
);

    localparam int unsigned WR  = R / P;
    localparam int unsigned WC  = C / P;
    localparam int unsigned N   = WR * WC;
    localparam int unsigned E   = R * C;
    localparam int unsigned PW  = $clog2(P);
    localparam int unsigned WRW = (WR > 1) ? $clog2(WR) : 1;
    localparam int unsigned WCW = (WC > 1) ? $clog2(WC) : 1;
    localparam int unsigned IW  = $clog2(E);
    localparam int unsigned JW  = (N > 1) ? $clog2(N) : 1;

    generate
        if ((R % P) != 0 || (C % P) != 0 || P < 2) begin : g_bad_geometry
            $error("max_pool_seq: R and C must be multiples of P, and P must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic signed [In_d_W-1:0]  map_q [E];
    logic signed [In_d_W-1:0]  map_d [E];
    logic signed [In_d_W-1:0]  buf_q [N];
    logic signed [In_d_W-1:0]  buf_d [N];
    logic signed [In_d_W-1:0]  acc_q, acc_d;
    logic [PW-1:0]             pr_q, pr_d, pc_q, pc_d;
    logic [WRW-1:0]            wr_q, wr_d;
    logic [WCW-1:0]            wc_q, wc_d;
    logic [In_d_W*N-1:0]       z_q, z_d;

    logic [IW-1:0]             idx;
    logic [JW-1:0]             slot;
    logic signed [In_d_W-1:0]  elem;
    logic signed [In_d_W-1:0]  win_max;
    logic                      first_el;
    logic                      last_el;
    logic                      last_col;
    logic                      last_row;

    // Address of the element under the scan: row wr*P+pr, column wc*P+pc.
    always_comb begin
        idx      = IW'((IW'(wr_q) * IW'(P) + IW'(pr_q)) * IW'(C)
                       + IW'(wc_q) * IW'(P) + IW'(pc_q));
        slot     = JW'(JW'(wr_q) * JW'(WC) + JW'(wc_q));
        elem     = map_q[idx];
        win_max  = (elem > acc_q) ? elem : acc_q;
        first_el = (pr_q == '0) && (pc_q == '0);
        last_el  = (pr_q == PW'(P - 1)) && (pc_q == PW'(P - 1));
        last_col = (wc_q == WCW'(WC - 1));
        last_row = (wr_q == WRW'(WR - 1));
    end

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        buf_d   = buf_q;
        acc_d   = acc_q;
        pr_d    = pr_q;
        pc_d    = pc_q;
        wr_d    = wr_q;
        wc_d    = wc_q;
        z_d     = z_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int unsigned i = 0; i < E; i++) begin
                        map_d[i] = X[i*In_d_W +: In_d_W];
                    end
                    pr_d    = '0;
                    pc_d    = '0;
                    wr_d    = '0;
                    wc_d    = '0;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                acc_d = first_el ? elem : win_max;
                // P >= 2, so the last element of a window never is its first.
                if (last_el) begin
                    buf_d[slot] = win_max;
                end

                if (pc_q == PW'(P - 1)) begin
                    pc_d = '0;
                    if (pr_q == PW'(P - 1)) begin
                        pr_d = '0;
                        if (last_col) begin
                            wc_d = '0;
                            if (last_row) begin
                                wr_d    = '0;
                                state_d = DONE;
                                // Publish from buf_d so the final window lands in Z too.
                                for (int unsigned k = 0; k < N; k++) begin
                                    z_d[k*In_d_W +: In_d_W] = buf_d[k];
                                end
                            end else begin
                                wr_d = wr_q + 1'b1;
                            end
                        end else begin
                            wc_d = wc_q + 1'b1;
                        end
                    end else begin
                        pr_d = pr_q + 1'b1;
                    end
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            map_q   <= '{default: '0};
            buf_q   <= '{default: '0};
            acc_q   <= '0;
            pr_q    <= '0;
            pc_q    <= '0;
            wr_q    <= '0;
            wc_q    <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            buf_q   <= buf_d;
            acc_q   <= acc_d;
            pr_q    <= pr_d;
            pc_q    <= pc_d;
            wr_q    <= wr_d;
            wc_q    <= wc_d;
            z_q     <= z_d;
        end
    end

    assign busy = (state_q == SCAN);
    assign done = (state_q == DONE);
    assign Z    = z_q;

endmodule

// File: tb/tb_max_pool_seq.sv
// Bench for max_pool_seq: default 4x4/P=2 instance plus a 6x6/P=3 instance,
// checked against a window-maximum reference model.
module tb_max_pool_seq;

    localparam int W  = 18;
    localparam int RA = 4, CA = 4, PA = 2, NA = 4, LA = 16;
    localparam int RB = 6, CB = 6, PB = 3, NB = 4, LB = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  clr_a, start_a, busy_a, done_a;
    logic [W*RA*CA-1:0]    x_a;
    logic [W*NA-1:0]       z_a;
    logic                  clr_b, start_b, busy_b, done_b;
    logic [W*RB*CB-1:0]    x_b;
    logic [W*NB-1:0]       z_b;

    int tests = 0;
    int fails = 0;

    max_pool_seq dut_a (
        .clk(clk), .clr(clr_a), .start(start_a), .X(x_a),
        .busy(busy_a), .done(done_a), .Z(z_a)
    );

    max_pool_seq #(.In_d_W(W), .R(RB), .C(CB), .P(PB)) dut_b (
        .clk(clk), .clr(clr_b), .start(start_b), .X(x_b),
        .busy(busy_b), .done(done_b), .Z(z_b)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: maximum over each non-overlapping p x p window, row-major windows.
    function automatic void pool_ref(input int r, input int c, input int p,
                                     input int e[$], output int res[$]);
        res = {};
        for (int wr = 0; wr < r / p; wr++) begin
            for (int wc = 0; wc < c / p; wc++) begin
                int m;
                m = e[wr * p * c + wc * p];
                for (int dr = 0; dr < p; dr++)
                    for (int dc = 0; dc < p; dc++)
                        if (e[(wr * p + dr) * c + wc * p + dc] > m)
                            m = e[(wr * p + dr) * c + wc * p + dc];
                res.push_back(m);
            end
        end
    endfunction

    function automatic int slot_a(input int j);
        return int'($signed(z_a[j*W +: W]));
    endfunction

    function automatic int slot_b(input int j);
        return int'($signed(z_b[j*W +: W]));
    endfunction

    function automatic int rnd_full();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    task automatic load_a(input int e[$]);
        for (int i = 0; i < RA * CA; i++) x_a[i*W +: W] = W'(e[i]);
    endtask

    // mode 0: plain, 1: rewrite X mid-scan, 2: extra start while busy, 3: clr abort
    task automatic run_a(input int e[$], input int mode, input string tag);
        int exp_z[$];
        int cyc, busy_cnt, late_done;
        pool_ref(RA, CA, PA, e, exp_z);
        load_a(e);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!done_a && cyc < 60) begin
            if (busy_a) busy_cnt++;
            if (mode == 1 && cyc == 3)
                for (int i = 0; i < RA * CA; i++) x_a[i*W +: W] = 18'h1FFFF;
            if (mode == 2 && cyc == 4) start_a = 1'b1;
            if (mode == 2 && cyc == 5) start_a = 1'b0;
            if (mode == 3 && cyc == 7) clr_a = 1'b1;
            if (mode == 3 && cyc == 8) begin
                clr_a = 1'b0;
                check({tag, "_clr_busy"}, longint'(busy_a), 0);
                check({tag, "_clr_done"}, longint'(done_a), 0);
                check({tag, "_clr_z"}, longint'(z_a != '0), 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (mode == 3) begin
            check({tag, "_no_done"}, longint'(done_a), 0);
        end else begin
            check({tag, "_latency"}, cyc, LA);
            check({tag, "_busy_cycles"}, busy_cnt, LA);
            check({tag, "_busy_at_done"}, longint'(busy_a), 0);
            for (int j = 0; j < NA; j++)
                check($sformatf("%s_z%0d", tag, j), slot_a(j), exp_z[j]);
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, longint'(done_a), 0);
            if (mode == 2) begin
                late_done = 0;
                for (int k = 0; k < 25; k++) begin
                    @(posedge clk); #1;
                    if (done_a) late_done++;
                end
                check({tag, "_single_done"}, late_done, 0);
            end
        end
    endtask

    task automatic run_b(input int e[$], input string tag);
        int exp_z[$];
        int cyc;
        pool_ref(RB, CB, PB, e, exp_z);
        for (int i = 0; i < RB * CB; i++) x_b[i*W +: W] = W'(e[i]);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, LB);
        for (int j = 0; j < NB; j++)
            check($sformatf("%s_z%0d", tag, j), slot_b(j), exp_z[j]);
    endtask

    initial begin
        int e[$];
        int exp_z[$];
        int t, last, pulses, zchg;
        logic [W*NA-1:0] zs;

        clr_a = 1'b1; start_a = 1'b0; x_a = '0;
        clr_b = 1'b1; start_b = 1'b0; x_b = '0;
        repeat (2) @(posedge clk);
        #1;
        clr_a = 1'b0;
        clr_b = 1'b0;
        check("rst_busy", longint'(busy_a), 0);
        check("rst_done", longint'(done_a), 0);
        check("rst_z", longint'(z_a != '0), 0);

        // Ramp 0..15
        e = {};
        for (int i = 0; i < 16; i++) e.push_back(i);
        run_a(e, 0, "ramp");
        check("ramp_slot0", slot_a(0), 5);
        check("ramp_slot1", slot_a(1), 7);
        check("ramp_slot2", slot_a(2), 13);
        check("ramp_slot3", slot_a(3), 15);

        // Signed window 0
        e = {};
        for (int i = 0; i < 16; i++) e.push_back(0);
        e[0] = -3; e[1] = -1; e[4] = -7; e[5] = -2;
        run_a(e, 0, "signed");
        check("signed_raw0", longint'(z_a[W-1:0]), 64'h3FFFF);

        // Rewrite X during scan
        e = {};
        for (int i = 0; i < 16; i++) e.push_back(rnd_full());
        run_a(e, 1, "rewrite");

        // Start pulse while busy
        e = {};
        for (int i = 0; i < 16; i++) e.push_back(rnd_full());
        run_a(e, 2, "restart");

        // Abort with clr, then a fresh run
        run_a(e, 3, "abort");
        e = {};
        for (int i = 0; i < 16; i++) e.push_back(15 - i);
        run_a(e, 0, "after_abort");

        // Randomized runs: full range and tie-heavy small range
        for (int n = 0; n < 6; n++) begin
            e = {};
            for (int i = 0; i < 16; i++) e.push_back(rnd_full());
            run_a(e, 0, $sformatf("rand%0d", n));
        end
        for (int n = 0; n < 3; n++) begin
            e = {};
            for (int i = 0; i < 16; i++) e.push_back(int'($urandom_range(0, 4)) - 2);
            run_a(e, 0, $sformatf("ties%0d", n));
        end

        // Start held high continuously
        e = {};
        for (int i = 0; i < 16; i++) e.push_back(rnd_full());
        pool_ref(RA, CA, PA, e, exp_z);
        load_a(e);
        start_a = 1'b1;
        t = 0; last = -1; pulses = 0; zchg = 0; zs = '0;
        while (pulses < 3 && t < 100) begin
            @(posedge clk); #1;
            t++;
            if (done_a) begin
                pulses++;
                for (int j = 0; j < NA; j++)
                    check($sformatf("hold_p%0d_z%0d", pulses, j), slot_a(j), exp_z[j]);
                if (last >= 0) check("hold_period", t - last, LA + 2);
                last = t;
                zs = z_a;
            end else if (last >= 0 && z_a !== zs) begin
                zchg++;
            end
        end
        start_a = 1'b0;
        check("hold_pulses", pulses, 3);
        check("hold_z_stable", zchg, 0);
        repeat (20) @(posedge clk);
        #1;

        // 6x6, P=3 instance
        e = {};
        for (int i = 0; i < 36; i++) e.push_back(35 - i);
        run_b(e, "b_ramp");
        check("b_slot0", slot_b(0), 35);
        check("b_slot1", slot_b(1), 32);
        check("b_slot2", slot_b(2), 17);
        check("b_slot3", slot_b(3), 14);
        repeat (3) @(posedge clk);
        #1;
        e = {};
        for (int i = 0; i < 36; i++) e.push_back(rnd_full());
        run_b(e, "b_rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
